spmm_out_drain: RTL and testbench

Output drain stage directly downstream of the SpMM core. It detects that a result tile is ready and issues the core's `out_start` burst. It captures the N×N result matrix, four rows per cycle over N/4 cycles, into a local tile buffer. It then streams the tile one row per cycle to a downstream consumer over a valid/ready handshake, which decouples the core from consumer backpressure.

---
 rtl/spmm_out_drain.sv | 166 ++++++++++++++++
 tb/tb_spmm_out_drain.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmm_out_drain.sv
// -----------------------------------------------------------------------------
// spmm_out_drain
// Output drain stage behind the SpMM core. A rising edge on out_ready
// triggers a burst request (out_start). The N x N result tile then arrives
// four rows per cycle over N/4 cycles and is captured into a local buffer.
// The buffered tile is then streamed one row per cycle to a consumer.
//
// Optional feature macro: DRAIN_CSUM_EN. When it is defined, a modulo-2^W
// checksum of the captured tile is accumulated and driven on the csum port.
//
// Ports:
//   clock, reset    clock and asynchronous active-high reset
//   out_ready       core result-ready flag; only its rising edge is used
//   out_start       burst request to the core, high for the first CAP cycle
//   out_data        core burst data; out_data[i] is row 4*grp+i
//   row_valid/row_ready/row_data/row_idx/row_last   consumer row stream
//   busy            FSM not idle
//   drop            sticky: a trigger arrived while busy
//   dbg_state       current FSM state (0 IDLE, 1 CAP, 2 SEND)
//   csum            tile checksum (DRAIN_CSUM_EN only)
//
// Handshake: a row transfers on a clock edge where row_valid and row_ready
// are both high. While row_valid is high and row_ready is low, row_data,
// row_idx and row_last hold. row_ready is ignored outside SEND.
// -----------------------------------------------------------------------------
module spmm_out_drain #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          out_ready,
  output logic                          out_start,
  input  logic [3:0][N-1:0][W-1:0]      out_data,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [N-1:0][W-1:0]           row_data,
  output logic [$clog2(N)-1:0]          row_idx,
  output logic                          row_last,
  output logic                          busy,
  output logic                          drop,
  output logic [1:0]                    dbg_state
`ifdef DRAIN_CSUM_EN
  ,
  output logic [W-1:0]                  csum
`endif
);

  localparam int PW = $clog2(N);
  localparam int GW = (N > 4) ? $clog2(N / 4) : 1;
  localparam logic [GW-1:0] GRP_LAST = GW'(N / 4 - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAP  = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    out_ready_q;
  logic                    out_start_q;
  logic                    drop_q;
  logic [GW-1:0]           grp_q;
  logic [PW-1:0]           ptr_q;
  logic [PW-1:0]           grp_base;
  logic [N-1:0][W-1:0]     tile_q [N];
  logic                    trig;
  logic                    handshake;

  assign trig      = out_ready & ~out_ready_q;
  assign handshake = (state_q == S_SEND) & row_ready;
  // First row of the group being captured; truncation makes this 0 when N=4.
  assign grp_base  = PW'({grp_q, 2'b00});

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trig) state_d = S_CAP;
      S_CAP:   if (grp_q == GRP_LAST) state_d = S_SEND;
      S_SEND:  if (handshake && (ptr_q == PTR_LAST)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; row outputs are forced to zero outside SEND so a reset
  // mid-tile clears them immediately.
  always_comb begin
    row_valid = 1'b0;
    row_data  = '0;
    row_idx   = '0;
    row_last  = 1'b0;
    if (state_q == S_SEND) begin
      row_valid = 1'b1;
      row_data  = tile_q[ptr_q];
      row_idx   = ptr_q;
      row_last  = (ptr_q == PTR_LAST);
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_start = out_start_q;
  assign drop      = drop_q;
  assign dbg_state = state_q;

  // Control registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_ready_q <= 1'b0;
      out_start_q <= 1'b0;
      drop_q      <= 1'b0;
      grp_q       <= '0;
      ptr_q       <= '0;
    end else begin
      out_ready_q <= out_ready;
      // Registered so it is high exactly in the first CAP cycle (grp == 0).
      out_start_q <= (state_q == S_IDLE) && trig;
      drop_q      <= drop_q | (trig && (state_q != S_IDLE));
      if (state_q == S_CAP) grp_q <= grp_q + 1'b1;
      else                  grp_q <= '0;
      if (state_q == S_CAP)  ptr_q <= '0;
      else if (handshake)    ptr_q <= ptr_q + 1'b1;
    end
  end

  // Tile buffer; contents need no reset.
  always_ff @(posedge clock) begin
    if (state_q == S_CAP) begin
      for (int i = 0; i < 4; i++) begin
        tile_q[grp_base + PW'(i)] <= out_data[i];
      end
    end
  end

`ifdef DRAIN_CSUM_EN
  logic [W-1:0] acc_q;
  logic [W-1:0] grp_sum;

  always_comb begin
    grp_sum = '0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < N; c++) begin
        grp_sum = grp_sum + out_data[i][c];
      end
    end
  end

  // Cleared on CAP entry, so the value stays valid through SEND and the
  // following IDLE until the next tile starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              acc_q <= '0;
    else if ((state_q == S_IDLE) && trig)   acc_q <= '0;
    else if (state_q == S_CAP)              acc_q <= acc_q + grp_sum;
  end

  assign csum = acc_q;
`endif

endmodule

// File: tb/tb_spmm_out_drain.sv
module tb_spmm_out_drain;
  localparam int N  = 16;
  localparam int W  = 8;
  localparam int PW = 4;

  logic                      clock;
  logic                      reset;
  logic                      out_ready;
  logic                      out_start;
  logic [3:0][N-1:0][W-1:0]  out_data;
  logic                      row_valid;
  logic                      row_ready;
  logic [N-1:0][W-1:0]       row_data;
  logic [PW-1:0]             row_idx;
  logic                      row_last;
  logic                      busy;
  logic                      drop;
  logic [1:0]                dbg_state;
`ifdef DRAIN_CSUM_EN
  logic [W-1:0]              csum;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 0;   // core data pattern
  int core_g   = 0;   // core burst group for cycles after the first
  int cap_g;
  logic [PW-1:0] exp_q[$];

  spmm_out_drain #(.N(N), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .out_ready (out_ready),
    .out_start (out_start),
    .out_data  (out_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .busy      (busy),
    .drop      (drop),
    .dbg_state (dbg_state)
`ifdef DRAIN_CSUM_EN
    ,
    .csum      (csum)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    row_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // ---------------- core model ----------------
  function automatic logic [W-1:0] elem(int r, int c);
    case (mode)
      0:       elem = W'(r * 16 + c);
      1:       elem = W'(1);
      2:       elem = W'(3);
      default: elem = (r == 0 && c == 0) ? W'(7) : W'(0);
    endcase
  endfunction

  function automatic logic [N-1:0][W-1:0] exp_row(int r);
    for (int c = 0; c < N; c++) exp_row[c] = elem(r, c);
  endfunction

  // The core presents group 0 with out_start, then groups 1..N/4-1 on the
  // following cycles; outside the burst it drives junk.
  always @(posedge clock or posedge reset) begin
    if (reset)                             core_g <= 0;
    else if (out_start)                    core_g <= 1;
    else if (core_g > 0 && core_g < N/4-1) core_g <= core_g + 1;
    else                                   core_g <= 0;
  end

  always_comb begin
    cap_g = out_start ? 0 : ((core_g > 0) ? core_g : -1);
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < N; c++)
        out_data[i][c] = (cap_g >= 0) ? elem(4 * cap_g + i, c) : W'(8'hEE);
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b0; row_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    n_checks++; if (out_start !== 1'b0) $display("FAIL reset_out_start got=%b exp=0", out_start); else n_pass++;
    n_checks++; if (row_valid !== 1'b0) $display("FAIL reset_row_valid got=%b exp=0", row_valid); else n_pass++;
    n_checks++; if (row_data !== '0) $display("FAIL reset_row_data got=%h exp=0", row_data); else n_pass++;
    n_checks++; if (row_idx !== '0) $display("FAIL reset_row_idx got=%0d exp=0", row_idx); else n_pass++;
    n_checks++; if (row_last !== 1'b0) $display("FAIL reset_row_last got=%b exp=0", row_last); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (drop !== 1'b0) $display("FAIL reset_drop got=%b exp=0", drop); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else n_pass++;
`ifdef DRAIN_CSUM_EN
    n_checks++; if (csum !== '0) $display("FAIL reset_csum got=%0d exp=0", csum); else n_pass++;
`endif
  endtask

  // Trigger sampled at edge k; negedge "cyc" lies in cycle k+cyc.
  task automatic test_drain();
    logic [PW-1:0] r;
    do_reset();
    mode = 0; row_ready = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clock);
      out_ready = 1'b0;
      n_checks++;
      if (out_start !== (cyc == 1)) $display("FAIL drain_out_start cyc=%0d got=%b exp=%b", cyc, out_start, cyc == 1); else n_pass++;
      n_checks++;
      if (row_valid !== (cyc >= 5 && cyc <= 20)) $display("FAIL drain_row_valid cyc=%0d got=%b", cyc, row_valid); else n_pass++;
      n_checks++;
      if (busy !== (cyc <= 20)) $display("FAIL drain_busy cyc=%0d got=%b exp=%b", cyc, busy, cyc <= 20); else n_pass++;
      if (cyc >= 5 && cyc <= 20) begin
        r = PW'(cyc - 5);
        n_checks++; if (row_idx !== r) $display("FAIL drain_row_idx got=%0d exp=%0d", row_idx, r); else n_pass++;
        n_checks++; if (row_last !== (cyc == 20)) $display("FAIL drain_row_last row=%0d got=%b", r, row_last); else n_pass++;
        n_checks++; if (row_data !== exp_row(cyc - 5)) $display("FAIL drain_row_data row=%0d got=%h exp=%h", r, row_data, exp_row(cyc - 5)); else n_pass++;
`ifdef DRAIN_CSUM_EN
        // sum of 0..255 = 32640, mod 256 = 128
        if (cyc == 5) begin
          n_checks++; if (csum !== 8'd128) $display("FAIL drain_csum got=%0d exp=128", csum); else n_pass++;
        end
`endif
      end
    end
    n_checks++; if (drop !== 1'b0) $display("FAIL drain_drop got=%b exp=0", drop); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int t = 0, hs = 0;
    do_reset();
    mode = 0; row_ready = 1'b0;
    for (int i = 0; i < N; i++) exp_q.push_back(PW'(i));
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
      @(negedge clock);
      out_ready = 1'b0;
      if (row_valid) begin
        n_checks++; if (row_idx !== exp_q[0]) $display("FAIL bp_row_idx got=%0d exp=%0d", row_idx, exp_q[0]); else n_pass++;
        n_checks++; if (row_data !== exp_row(int'(exp_q[0]))) $display("FAIL bp_row_data row=%0d got=%h", exp_q[0], row_data); else n_pass++;
        n_checks++; if (row_last !== (exp_q[0] == PW'(N-1))) $display("FAIL bp_row_last row=%0d got=%b", exp_q[0], row_last); else n_pass++;
        row_ready = pat[t % 4];
        t++;
        if (row_ready) begin
          void'(exp_q.pop_front());
          hs++;
        end
      end else begin
        row_ready = 1'b0;
      end
    end
    n_checks++; if (hs !== 16) $display("FAIL bp_handshakes got=%0d exp=16", hs); else n_pass++;
    exp_q.delete();
    @(negedge clock);
    row_ready = 1'b1;
    n_checks++; if (row_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle_after got=%b%b exp=00", row_valid, busy); else n_pass++;
  endtask

  task automatic test_held_level();
    int starts = 0, rows = 0;
    do_reset();
    mode = 0; row_ready = 1'b1;
    out_ready = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (out_start) starts++;
      if (row_valid) rows++;
    end
    n_checks++; if (starts !== 1) $display("FAIL held_starts got=%0d exp=1", starts); else n_pass++;
    n_checks++; if (rows !== 16) $display("FAIL held_rows got=%0d exp=16", rows); else n_pass++;
    n_checks++; if (drop !== 1'b0) $display("FAIL held_drop got=%b exp=0", drop); else n_pass++;
    // New tile, then a second rising edge while it is in SEND.
    out_ready = 1'b0;
    @(negedge clock);
    out_ready = 1'b1;
    starts = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clock);
      if (out_start) starts++;
      if (cyc == 6) out_ready = 1'b0;
      if (cyc == 7) begin
        n_checks++; if (drop !== 1'b0) $display("FAIL held_drop_before got=%b exp=0", drop); else n_pass++;
        out_ready = 1'b1;
      end
      if (cyc == 8) begin
        n_checks++; if (drop !== 1'b1) $display("FAIL held_drop_set got=%b exp=1", drop); else n_pass++;
      end
    end
    n_checks++; if (starts !== 1) $display("FAIL held_second_starts got=%0d exp=1", starts); else n_pass++;
    n_checks++; if (busy !== 1'b0 || drop !== 1'b1) $display("FAIL held_end busy=%b drop=%b exp busy=0 drop=1", busy, drop); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_last_handshake();
    int starts = 0;
    do_reset();
    mode = 0; row_ready = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clock);
      out_ready = 1'b0;
      if (cyc > 1 && out_start) starts++;
      if (cyc == 20) begin
        n_checks++; if (row_last !== 1'b1 || drop !== 1'b0) $display("FAIL lh_setup row_last=%b drop=%b exp 1,0", row_last, drop); else n_pass++;
        out_ready = 1'b1;  // rises in the cycle of the final handshake
      end
      if (cyc == 21) begin
        n_checks++; if (drop !== 1'b1) $display("FAIL lh_drop got=%b exp=1", drop); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL lh_busy got=%b exp=0", busy); else n_pass++;
      end
    end
    n_checks++; if (starts !== 0) $display("FAIL lh_extra_start got=%0d exp=0", starts); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    logic seen = 1'b0;
    do_reset();
    mode = 0; row_ready = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
      @(negedge clock);
      out_ready = 1'b0;
      if (row_valid && row_idx == PW'(5)) seen = 1'b1;
    end
    n_checks++; if (!seen) $display("FAIL rm_reach_row5 got=timeout exp=row5"); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (row_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rm_clear valid=%b busy=%b exp 0,0", row_valid, busy); else n_pass++;
    n_checks++; if (row_data !== '0 || row_idx !== '0 || row_last !== 1'b0) $display("FAIL rm_row_clear data=%h idx=%0d last=%b", row_data, row_idx, row_last); else n_pass++;
    n_checks++; if (out_start !== 1'b0 || drop !== 1'b0) $display("FAIL rm_ctl_clear start=%b drop=%b", out_start, drop); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    repeat (25) begin
      @(negedge clock);
      if (row_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL rm_after_release got=%0d active cycles exp=0", bad); else n_pass++;
  endtask

`ifdef DRAIN_CSUM_EN
  task automatic test_csum();
    int modes [3] = '{3, 1, 2};
    logic [W-1:0] exps [3] = '{8'd7, 8'd0, 8'd0};
    logic got;
    do_reset();
    row_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mode = modes[k];
      out_ready = 1'b1;
      got = 1'b0;
      for (int cyc = 0; cyc < 30 && !got; cyc++) begin
        @(negedge clock);
        out_ready = 1'b0;
        if (row_valid) got = 1'b1;
      end
      n_checks++; if (!got || csum !== exps[k]) $display("FAIL csum_mode%0d got=%0d exp=%0d", modes[k], csum, exps[k]); else n_pass++;
      repeat (20) @(negedge clock);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; out_ready = 1'b0; row_ready = 1'b0;
    test_reset();
    test_drain();
    test_backpressure();
    test_held_level();
    test_last_handshake();
    test_reset_mid();
`ifdef DRAIN_CSUM_EN
    test_csum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
